// File: rtl/axis_level_fifo.sv
// Synchronous AXI-stream FIFO with fill level, watermarks and flush; any depth >= 2.
// Define AXIS_LEVEL_FIFO_STATS_EN to build the hwm / stall_cnt statistics counters.
module axis_level_fifo #(
    parameter type DATA_TYPE  = logic [7:0],
    parameter int  FIFO_DEPTH = 16,
    parameter int  AF_THRESH  = FIFO_DEPTH - 2,
    parameter int  AE_THRESH  = 2,
    localparam int LW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  DATA_TYPE      axis_i_data,
    input  logic          axis_i_vld,
    output logic          axis_i_rdy,
    output DATA_TYPE      axis_o_data,
    output logic          axis_o_vld,
    input  logic          axis_o_rdy,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [LW-1:0] level,
    output logic [LW-1:0] hwm,
    output logic [15:0]   stall_cnt
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(FIFO_DEPTH - 1);
    localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] AF_L     = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_L     = LW'(AE_THRESH);

    DATA_TYPE      mem [FIFO_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          wr_ok;
    logic          rd_ok;

    // Explicit wrap so non-power-of-two depths index only valid entries.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    assign full         = (level == DEPTH_L);
    assign empty        = (level == '0);
    assign almost_full  = (level >= AF_L);
    assign almost_empty = (level <= AE_L);

    assign axis_i_rdy  = ~full & ~flush;
    assign axis_o_vld  = ~empty & ~flush;
    assign axis_o_data = mem[rptr];

    assign wr_ok = axis_i_vld & axis_i_rdy;
    assign rd_ok = axis_o_vld & axis_o_rdy;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr] <= axis_i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= next_ptr(wptr);
            end
            if (rd_ok) begin
                rptr <= next_ptr(rptr);
            end
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

`ifdef AXIS_LEVEL_FIFO_STATS_EN
    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hwm       <= '0;
            stall_cnt <= '0;
        end else begin
            if (level > hwm) begin
                hwm <= level;
            end
            if (axis_i_vld && !axis_i_rdy && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`else
    assign hwm       = '0;
    assign stall_cnt = '0;
`endif

endmodule
